load_store_unit: RTL and testbench

- MEM-stage load/store unit. Sits between the EX/MEM pipeline register and a variable-latency, word-organised data memory, replacing the fixed single-cycle data memory access.
- Generates word-aligned requests with byte enables, runs a req/ack handshake, and aligns and sign/zero-extends load data.
- Stalls the pipeline while an access is outstanding and flags misaligned, illegal or timed-out accesses.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_lane_align.sv | 69 ++++++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   lsu_state_e  - handshake FSM states (IDLE, WAIT, DONE)
//   F3_*         - func3 access size/sign encodings
//   is_aligned() - natural-alignment check for a func3 and byte offset
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte accesses are always aligned; halfwords need an even offset and
  // words need offset zero. Unknown encodings are rejected elsewhere.
  function automatic logic is_aligned(input logic [2:0] func3, input logic [1:0] off);
    case (func3)
      F3_H, F3_HU: is_aligned = ~off[0];
      F3_W:        is_aligned = (off == 2'b00);
      default:     is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the load/store unit.
// Ports:
//   st_func3, st_off, st_data -> st_be, st_wdata : store byte enables and
//                                lane-replicated store data
//   ld_func3, ld_off, ld_word -> ld_data         : load lane extract with
//                                sign/zero extension
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_func3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Stores replicate the datum across every lane it could land in, so the
  // memory only has to honour the byte enables.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'h0;
    case (st_func3)
      F3_B: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      F3_W: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
      default: begin
        st_be    = 4'b0000;
        st_wdata = 32'h0;
      end
    endcase
  end

  // Loads pick the addressed lane out of the full word, then extend.
  always_comb begin
    ld_byte = 8'h0;
    case (ld_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    case (ld_func3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store unit in front of a variable-latency,
// word-organised data memory.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   mem_read, mem_write   - access request from EX/MEM
//   addr, wr_data, func3  - byte address, store data, access size/sign
//   stall                 - holds the front of the pipeline during an access
//   rd_data, rd_valid     - aligned/extended load result and its valid pulse
//   access_err            - pulse for misaligned/illegal/conflicting/timed-out access
//   dm_req, dm_we, dm_addr, dm_be, dm_wdata - memory request side
//   dm_ack, dm_rdata      - memory completion and read word
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic                  stall,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  access_err,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [DM_ADDRESS-1:0] dm_addr,
  output logic [3:0]            dm_be,
  output logic [DATA_W-1:0]     dm_wdata,
  input  logic                  dm_ack,
  input  logic [DATA_W-1:0]     dm_rdata
);

  // Last WAIT cycle index before the access is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state;
  logic [7:0]  cnt;
  logic [2:0]  cap_func3;
  logic [1:0]  cap_off;

  logic        new_acc;
  logic        f3_ok;
  logic        start_ok;
  logic        start_bad;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  lsu_lane_align u_lane_align (
    .st_func3 (func3),
    .st_off   (addr[1:0]),
    .st_data  (wr_data),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_func3 (cap_func3),
    .ld_off   (cap_off),
    .ld_word  (dm_rdata),
    .ld_data  (ld_data)
  );

  // Unsigned variants only exist for loads; with exactly one of
  // mem_read/mem_write set, mem_read identifies a load.
  always_comb begin
    new_acc = mem_read ^ mem_write;
    f3_ok   = 1'b0;
    case (func3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = mem_read;
      default:          f3_ok = 1'b0;
    endcase
    start_ok  = (state == IDLE) && new_acc && f3_ok && is_aligned(func3, addr[1:0]);
    start_bad = (state == IDLE) && (mem_read | mem_write) && !start_ok;
  end

  // Stall covers the detect cycle and every WAIT cycle; reset overrides it so
  // the pipeline is free to flush.
  assign stall  = reset && (start_ok || (state == WAIT));
  assign dm_req = (state == WAIT);

  // Handshake FSM with capture registers. Request fields are captured on
  // entry to WAIT and left untouched until the next access, which keeps them
  // stable for the whole handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      cap_func3  <= 3'b000;
      cap_off    <= 2'b00;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_be      <= 4'b0000;
      dm_wdata   <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      access_err <= 1'b0;
    end else begin
      rd_valid   <= 1'b0;
      access_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            cnt       <= 8'd0;
            cap_func3 <= func3;
            cap_off   <= addr[1:0];
            dm_we     <= mem_write;
            dm_addr   <= {addr[DM_ADDRESS-1:2], 2'b00};
            dm_be     <= mem_write ? st_be : 4'b1111;
            dm_wdata  <= mem_write ? st_wdata : '0;
            state     <= WAIT;
          end else if (start_bad) begin
            access_err <= 1'b1;
            rd_data    <= '0;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (dm_ack) begin
            if (!dm_we) begin
              rd_data  <= ld_data;
              rd_valid <= 1'b1;
            end
            state <= DONE;
          end else if (cnt == TO_LAST) begin
            access_err <= 1'b1;
            rd_data    <= '0;
            state      <= DONE;
          end
        end
        DONE: begin
          cnt   <= 8'd0;
          state <= IDLE;
        end
        default: begin
          cnt   <= 8'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomized bench for load_store_unit,
// checked against a size/offset arithmetic model of the access rules.
module tb_load_store_unit;

  localparam int DATA_W     = 32;
  localparam int DM_ADDRESS = 9;
  localparam int TIMEOUT    = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  mem_read;
  logic                  mem_write;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wr_data;
  logic [2:0]            func3;
  logic                  stall;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  access_err;
  logic                  dm_req;
  logic                  dm_we;
  logic [DM_ADDRESS-1:0] dm_addr;
  logic [3:0]            dm_be;
  logic [DATA_W-1:0]     dm_wdata;
  logic                  dm_ack;
  logic [DATA_W-1:0]     dm_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = 32'h0;

  load_store_unit #(
    .DATA_W     (DATA_W),
    .DM_ADDRESS (DM_ADDRESS),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wr_data    (wr_data),
    .func3      (func3),
    .stall      (stall),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .access_err (access_err),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_be      (dm_be),
    .dm_wdata   (dm_wdata),
    .dm_ack     (dm_ack),
    .dm_rdata   (dm_rdata)
  );

  always #5 clk = ~clk;

  // Access size in bytes, 0 for an unknown encoding.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                     input logic [8:0] a);
    int sz;
    sz = size_of(f3);
    if (rd == wr) return 1'b0;
    if (sz == 0) return 1'b0;
    if (wr && f3[2]) return 1'b0;
    return (int'(a) % sz) == 0;
  endfunction

  function automatic logic [3:0] model_be(input bit wr, input logic [2:0] f3, input logic [8:0] a);
    int sz;
    sz = size_of(f3);
    if (!wr) return 4'hF;
    return 4'(((1 << sz) - 1) << (int'(a) % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (size_of(f3))
      1:       return (w & 32'hFF) * 32'h01010101;
      2:       return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [8:0] a,
                                             input logic [31:0] w);
    int sz;
    logic [31:0] v, mask;
    sz = size_of(f3);
    if (sz == 4) return w;
    v    = w >> (8 * (int'(a) % 4));
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    v    = v & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3,
                               input logic [8:0] a, input logic [31:0] wd);
    mem_read  = rd;
    mem_write = wr;
    func3     = f3;
    addr      = a;
    wr_data   = wd;
  endtask

  // One complete access. ack_at is the WAIT cycle (1-based) in which the
  // memory acknowledges; 0 means it never does and the access times out.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [8:0] a, input logic [31:0] wd,
                            input logic [31:0] rdv, input int ack_at);
    bit legal;
    int n;
    legal = model_legal(rd, wr, f3, a);
    @(negedge clk);
    applyStimulus(rd, wr, f3, a, wd);
    dm_ack = 1'b0;
    #1;
    checkOutput("issue_stall", stall, legal);
    checkOutput("issue_req", dm_req, 0);
    if (!legal) begin
      @(negedge clk);
      applyStimulus(0, 0, 3'b000, 9'h0, 32'h0);
      #1;
      exp_rd = 32'h0;
      checkOutput("err_pulse", access_err, 1);
      checkOutput("err_rd_data", rd_data, exp_rd);
      checkOutput("err_rd_valid", rd_valid, 0);
      checkOutput("err_req", dm_req, 0);
      checkOutput("err_stall", stall, 0);
      @(negedge clk);
      #1;
      checkOutput("err_clear", access_err, 0);
      return;
    end
    n = (ack_at == 0) ? TIMEOUT : ack_at;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      dm_ack   = (i == ack_at);
      dm_rdata = rdv;
      #1;
      checkOutput("wait_req", dm_req, 1);
      checkOutput("wait_stall", stall, 1);
      checkOutput("wait_addr", dm_addr, {a[8:2], 2'b00});
      checkOutput("wait_we", dm_we, wr);
      checkOutput("wait_be", dm_be, model_be(wr, f3, a));
      if (wr) checkOutput("wait_wdata", dm_wdata, model_wdata(f3, wd));
    end
    @(negedge clk);
    dm_ack = 1'b0;
    #1;
    if (ack_at == 0) exp_rd = 32'h0;
    else if (rd) exp_rd = model_load(f3, a, rdv);
    checkOutput("done_stall", stall, 0);
    checkOutput("done_req", dm_req, 0);
    checkOutput("done_valid", rd_valid, (ack_at != 0) && rd);
    checkOutput("done_err", access_err, ack_at == 0);
    checkOutput("done_rd_data", rd_data, exp_rd);
    // Back in IDLE: the request held during DONE must not restart, and a
    // stray ack must not disturb anything.
    @(negedge clk);
    applyStimulus(0, 0, 3'b000, 9'h0, 32'h0);
    dm_ack   = 1'b1;
    dm_rdata = $urandom;
    #1;
    checkOutput("idle_req", dm_req, 0);
    checkOutput("idle_valid", rd_valid, 0);
    checkOutput("idle_err", access_err, 0);
    checkOutput("idle_stall", stall, 0);
    checkOutput("idle_rd_hold", rd_data, exp_rd);
  endtask

  initial begin
    int sel;
    bit rd, wr;
    logic [2:0] f3;
    logic [8:0] a;

    reset    = 1'b0;
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    applyStimulus(1, 0, 3'b010, 9'h08, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_req", dm_req, 0);
    checkOutput("rst_we", dm_we, 0);
    checkOutput("rst_addr", dm_addr, 0);
    checkOutput("rst_be", dm_be, 0);
    checkOutput("rst_wdata", dm_wdata, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_valid", rd_valid, 0);
    checkOutput("rst_err", access_err, 0);
    applyStimulus(0, 0, 3'b000, 9'h0, 32'h0);
    reset = 1'b1;

    $display("[TB] directed accesses");
    run_access(0, 1, 3'b010, 9'h008, 32'hDEADBEEF, 32'h0, 1);
    run_access(1, 0, 3'b000, 9'h00B, 32'h0, 32'h80FF1234, 3);
    run_access(1, 0, 3'b100, 9'h00B, 32'h0, 32'h80FF1234, 3);
    run_access(0, 1, 3'b001, 9'h006, 32'h0000ABCD, 32'h0, 2);
    run_access(1, 0, 3'b001, 9'h002, 32'h0, 32'h7FFF0000, 1);
    run_access(1, 0, 3'b010, 9'h005, 32'h0, 32'h0, 1);
    run_access(1, 1, 3'b010, 9'h008, 32'h12345678, 32'h0, 1);
    run_access(1, 0, 3'b011, 9'h008, 32'h0, 32'h0, 1);
    run_access(0, 1, 3'b100, 9'h010, 32'h55, 32'h0, 1);
    run_access(1, 0, 3'b010, 9'h00C, 32'h0, 32'hCAFEF00D, 0);

    $display("[TB] reset during WAIT");
    run_access(1, 0, 3'b010, 9'h020, 32'h0, 32'h11223344, 1);
    @(negedge clk);
    applyStimulus(1, 0, 3'b010, 9'h040, 32'h0);
    dm_ack = 1'b0;
    #1;
    checkOutput("rw_issue_stall", stall, 1);
    @(negedge clk);
    #1;
    checkOutput("rw_wait1_req", dm_req, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rw_forced_stall", stall, 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 0, 3'b000, 9'h0, 32'h0);
    dm_ack   = 1'b1;
    dm_rdata = 32'hA5A5A5A5;
    #1;
    exp_rd = 32'h0;
    checkOutput("rw_req", dm_req, 0);
    checkOutput("rw_addr", dm_addr, 0);
    checkOutput("rw_be", dm_be, 0);
    checkOutput("rw_rd_data", rd_data, 0);
    checkOutput("rw_valid", rd_valid, 0);
    @(negedge clk);
    dm_ack = 1'b0;
    #1;
    checkOutput("rw_late_ack_valid", rd_valid, 0);
    checkOutput("rw_late_ack_req", dm_req, 0);
    run_access(1, 0, 3'b010, 9'h040, 32'h0, 32'h0BADC0DE, 2);

    $display("[TB] randomized accesses");
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel < 5) || (sel == 9);
      wr  = (sel >= 5);
      f3  = 3'($urandom_range(0, 7));
      a   = 9'($urandom);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_access(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
